// File: rtl/tx_framer_pkg.sv
// Shared constants and types for the 8b10b transmit framer: the four K-codes
// the framer emits and the framer FSM state type.
package tx_framer_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // idle / comma
  localparam logic [7:0] K27_7 = 8'hFB;  // start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // end of packet
  localparam logic [7:0] K23_7 = 8'hF7;  // fill on upstream underrun

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    EOP  = 2'd2
  } tx_framer_state_t;

endpackage

// File: rtl/tx_framer_8b10b.sv
// AXI-Stream byte stream to continuous K/data symbol stream for an 8b10b encoder.
// Define TX_FRAMER_ALIGN_EN to insert periodic K28.5 alignment commas inside frames.
module tx_framer_8b10b
  import tx_framer_pkg::*;
#(
  parameter int IFG_MIN      = 2,
  parameter int ALIGN_PERIOD = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] m_code_8b,
  output logic       m_is_k,
  output logic       m_valid,
  input  logic       m_ready
);

  localparam logic [7:0] IFG_MIN_C = 8'(IFG_MIN);

  tx_framer_state_t state_q, state_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [7:0]       code_q, code_d;
  logic             is_k_q, is_k_d;
  logic             valid_q, valid_d;
  logic             advance;
  logic             align_due;

  assign advance = !valid_q || m_ready;

  // A byte is never taken while reset is asserted, since that frame is abandoned.
  assign s_tready = advance && (state_q == DATA) && !align_due && !reset;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    code_d    = code_q;
    is_k_d    = is_k_q;
    valid_d   = valid_q;
    if (advance) begin
      valid_d = 1'b1;
      is_k_d  = 1'b1;
      unique case (state_q)
        IDLE: begin
          if ((gap_cnt_q >= IFG_MIN_C) && s_tvalid) begin
            code_d  = K27_7;
            state_d = DATA;
          end else begin
            code_d = K28_5;
            if (gap_cnt_q != 8'hFF) gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
        DATA: begin
          if (align_due) begin
            code_d = K28_5;
          end else if (s_tvalid) begin
            code_d = s_tdata;
            is_k_d = 1'b0;
            if (s_tlast) state_d = EOP;
          end else begin
            code_d = K23_7;
          end
        end
        EOP: begin
          if (align_due) begin
            code_d = K28_5;
          end else begin
            code_d    = K29_7;
            gap_cnt_d = 8'd0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= IFG_MIN_C;
      code_q    <= K28_5;
      is_k_q    <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      code_q    <= code_d;
      is_k_q    <= is_k_d;
      valid_q   <= valid_d;
    end
  end

`ifdef TX_FRAMER_ALIGN_EN
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_PERIOD - 1);

  logic [15:0] align_cnt_q, align_cnt_d;

  assign align_due = (align_cnt_q == ALIGN_LAST);

  // Counts consecutive non-comma symbols; a data byte of 0xBC is not a comma.
  always_comb begin
    align_cnt_d = align_cnt_q;
    if (advance) begin
      align_cnt_d = (is_k_d && (code_d == K28_5)) ? 16'd0 : align_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) align_cnt_q <= 16'd0;
    else       align_cnt_q <= align_cnt_d;
  end
`else
  logic unused_align_period;

  assign align_due           = 1'b0;
  assign unused_align_period = ^ALIGN_PERIOD;
`endif

  assign m_code_8b = code_q;
  assign m_is_k    = is_k_q;
  assign m_valid   = valid_q;

endmodule

// File: tb/tb_tx_framer_8b10b.sv
// Self-checking bench for tx_framer_8b10b: directed test-plan sequences plus
// randomized frames, checked by a protocol-level parser of the symbol stream.
module tb_tx_framer_8b10b;
  import tx_framer_pkg::*;

  localparam int IFG = 2;
`ifdef TX_FRAMER_ALIGN_EN
  localparam int AP = 8;
`else
  localparam int AP = 256;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic [7:0] m_code_8b;
  logic       m_is_k;
  logic       m_valid;
  logic       m_ready;

  tx_framer_8b10b #(.IFG_MIN(IFG), .ALIGN_PERIOD(AP)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_code_8b(m_code_8b),
    .m_is_k   (m_is_k),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic       acc;
  logic [8:0] sym_q[$];   // {is_k, code} of every symbol handed downstream
  logic [8:0] byte_q[$];  // {last, data} of every byte accepted upstream
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, log handshakes, then check outputs after the edge.
  task automatic cycle(input logic rst, input logic v, input logic [7:0] d,
                       input logic l, input logic rdy);
    logic       pv;
    logic [8:0] psym;
    reset = rst; s_tvalid = v; s_tdata = d; s_tlast = l; m_ready = rdy;
    #1;
    pv   = m_valid;
    psym = {m_is_k, m_code_8b};
    acc  = !rst && v && s_tready;
    if (!rst && pv && rdy) sym_q.push_back(psym);
    if (acc) byte_q.push_back({l, d});
    if (!rst && pv && !rdy) check("stall_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    if (rst) begin
      check("reset_out", 32'({m_valid, m_is_k, m_code_8b, s_tready}), 32'({1'b0, 1'b1, K28_5, 1'b0}));
    end else begin
      if (acc) check("latency", 32'({m_valid, m_is_k, m_code_8b}), 32'({1'b1, 1'b0, d}));
      if (pv && !rdy) check("hold", 32'({m_valid, m_is_k, m_code_8b}), 32'({1'b1, psym}));
      else            check("valid", 32'(m_valid), 32'd1);
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0,
                     rnd ? logic'($urandom_range(0, 9) < 7) : 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input bit rnd);
    int n = 0;
    do begin
      cycle(1'b0, 1'b1, d, l, rnd ? logic'($urandom_range(0, 9) < 7) : 1'b1);
      n++;
    end while (!acc && n < 64);
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic clear_logs();
    sym_q.delete();
    byte_q.delete();
  endtask

  task automatic expect_seq(input string tag, input bit skip_idle);
    int i = 0;
    if (skip_idle) while (i < sym_q.size() && sym_q[i] == {1'b1, K28_5}) i++;
    check({tag, "_len"}, 32'(sym_q.size() - i >= exp_q.size()), 32'd1);
    foreach (exp_q[j])
      check(tag, 32'((i + j < sym_q.size()) ? sym_q[i + j] : 9'h1FF), 32'(exp_q[j]));
  endtask

  // Parse the symbol stream into frames and compare payload with accepted bytes.
  task automatic check_stream(input string tag);
    logic [8:0] got[$];
    logic [8:0] s;
    bit in_frame = 0;
    int gap = IFG, n_in = 0, bad_out = 0, bad_in = 0, bad_gap = 0;
`ifdef TX_FRAMER_ALIGN_EN
    int run = 0, max_run = 0;
`endif
    foreach (sym_q[i]) begin
      s = sym_q[i];
`ifdef TX_FRAMER_ALIGN_EN
      if (s == {1'b1, K28_5}) run = 0;
      else begin run++; if (run > max_run) max_run = run; end
`endif
      if (!in_frame) begin
        if (s == {1'b1, K27_7}) begin
          if (gap < IFG) bad_gap++;
          in_frame = 1; n_in = 0;
        end else if (s == {1'b1, K28_5}) gap++;
        else bad_out++;
      end else if (!s[8]) begin
        got.push_back(s); n_in++;
      end else if (s == {1'b1, K23_7}) begin
      end else if (s == {1'b1, K29_7}) begin
        if (n_in == 0) bad_in++;
        else got[got.size() - 1][8] = 1'b1;
        in_frame = 0; gap = 0;
      end
`ifdef TX_FRAMER_ALIGN_EN
      else if (s == {1'b1, K28_5}) begin
      end
`endif
      else bad_in++;
    end
    check({tag, "_outside"}, 32'(bad_out), 32'd0);
    check({tag, "_inframe"}, 32'(bad_in), 32'd0);
    check({tag, "_ifg"}, 32'(bad_gap), 32'd0);
    check({tag, "_closed"}, 32'(in_frame), 32'd0);
`ifdef TX_FRAMER_ALIGN_EN
    check({tag, "_align_run"}, 32'(max_run <= AP - 1), 32'd1);
`endif
    check({tag, "_nbytes"}, 32'(got.size()), 32'(byte_q.size()));
    foreach (byte_q[i])
      check({tag, "_payload"}, 32'((i < got.size()) ? got[i] : 9'h1FF), 32'(byte_q[i]));
  endtask

  initial begin
    s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_ready = 1'b1; reset = 1'b1;

    // Reset and idle line
    repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (4) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("idle", 32'({m_valid, m_is_k, m_code_8b}), 32'({1'b1, 1'b1, K28_5}));
    end

    // Single frame
    clear_logs();
    send_byte(8'h01, 1'b0, 0); send_byte(8'h02, 1'b0, 0); send_byte(8'h03, 1'b1, 0);
    idle(4, 0);
    exp_q = '{9'h1FB, 9'h001, 9'h002, 9'h003, 9'h1FD, 9'h1BC, 9'h1BC};
    expect_seq("single", 1);
    check_stream("single");

    // Underrun fill
    clear_logs();
    send_byte(8'hAA, 1'b0, 0);
    idle(2, 0);
    send_byte(8'hBB, 1'b1, 0);
    idle(4, 0);
    exp_q = '{9'h1FB, 9'h0AA, 9'h1F7, 9'h1F7, 9'h0BB, 9'h1FD};
    expect_seq("underrun", 1);
    check_stream("underrun");

    // Backpressure mid-frame
    clear_logs();
    send_byte(8'h10, 1'b0, 0); send_byte(8'h11, 1'b0, 0);
    repeat (5) cycle(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 0); send_byte(8'h13, 1'b1, 0);
    idle(4, 0);
    exp_q = '{9'h1FB, 9'h010, 9'h011, 9'h012, 9'h013, 9'h1FD};
    expect_seq("backpressure", 1);
    check_stream("backpressure");

    // Back-to-back frames: exactly IFG commas between EOP and SOP
    clear_logs();
    send_byte(8'h21, 1'b0, 0); send_byte(8'h22, 1'b1, 0);
    send_byte(8'h31, 1'b0, 0); send_byte(8'h32, 1'b1, 0);
    idle(4, 0);
    exp_q = '{9'h1FB, 9'h021, 9'h022, 9'h1FD};
    repeat (IFG) exp_q.push_back(9'h1BC);
    exp_q.push_back(9'h1FB); exp_q.push_back(9'h031);
    exp_q.push_back(9'h032); exp_q.push_back(9'h1FD);
    expect_seq("b2b", 1);
    check_stream("b2b");

    // Long frame (alignment commas when enabled, none otherwise)
    clear_logs();
    for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i), logic'(i == 19), 0);
    idle(4, 0);
    check_stream("long");

    // Randomized frames, gaps and backpressure
    clear_logs();
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 10);
      idle($urandom_range(0, 3), 1);
      for (int b = 0; b < len; b++)
        send_byte(8'($urandom_range(0, 255)), logic'(b == len - 1), 1);
    end
    idle(6, 0);
    check_stream("random");

    // Reset mid-frame, then the first frame needs no gap
    send_byte(8'h55, 1'b0, 0); send_byte(8'h66, 1'b0, 0);
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    clear_logs();
    send_byte(8'h77, 1'b1, 0);
    idle(4, 0);
    exp_q = '{9'h1FB, 9'h077, 9'h1FD, 9'h1BC};
    expect_seq("post_reset", 0);
    check_stream("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
